// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_pkg
//  Brief    : Shared types and constants for the TDM serial-audio receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

   // Receiver sequencing states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DELAY = 3'd1,
      SHIFT = 3'd2,
      DONE  = 3'd3,
      WAIT  = 3'd4
   } tdm_state_t;

   // Framing modes selected by i_mode
   localparam logic MODE_I2S = 1'b0;
   localparam logic MODE_LJ  = 1'b1;

   // Default geometry
   localparam int DEF_DATA_RES = 24;
   localparam int DEF_SLOT_W   = 32;
   localparam int DEF_NUM_CH   = 2;

   // One received sample at the default resolution (slot MSB is the sign)
   typedef logic signed [DEF_DATA_RES-1:0] tdm_sample_t;

   // Width of a counter/index covering 0..n-1, never less than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_rx_if
//  Brief    : Frame output bus of tdm_rx: parallel frame, valid/ready and
//             status pulses. master = receiver, slave = frame consumer.
//  Revision : 1.0 - initial release
// ============================================================================
interface tdm_rx_if
   import tdm_pkg::*;
#(
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int DATA_RES = DEF_DATA_RES
);
   logic [NUM_CH-1:0][DATA_RES-1:0] o_data;       // [0] = slot 0 (left)
   logic                            o_valid;
   logic                            i_ready;
   logic                            o_overrun;    // completed frame dropped
   logic                            o_frame_err;  // fsync fall at wrong bit count

   modport master (
      output o_data, o_valid, o_overrun, o_frame_err,
      input  i_ready
   );

   modport slave (
      input  o_data, o_valid, o_overrun, o_frame_err,
      output i_ready
   );
endinterface
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_slot_counter
//  Brief    : Bit-within-slot and slot-within-frame position counter with a
//             flag marking the last bit of the last slot.
//             i_clear rebases to bit 0 / slot 0; i_step advances one bit.
//             Both together leave the counter at bit 1 of slot 0.
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_slot_counter
   import tdm_pkg::*;
#(
   parameter int SLOT_W  = DEF_SLOT_W,
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int BIT_W   = cnt_width(SLOT_W),
   parameter int SLOT_CW = cnt_width(NUM_CH)
) (
   input  logic               mclk,
   input  logic               reset_n,
   input  logic               i_clear,
   input  logic               i_step,
   output logic [BIT_W-1:0]   o_bit_cnt,
   output logic [SLOT_CW-1:0] o_slot_cnt,
   output logic               o_last_bit
);

   logic [BIT_W-1:0]   bit_q,  bit_d,  w_base_bit;
   logic [SLOT_CW-1:0] slot_q, slot_d, w_base_slot;

   // Next position: optional rebase to zero, then optional single-bit advance
   always_comb begin
      w_base_bit  = i_clear ? '0 : bit_q;
      w_base_slot = i_clear ? '0 : slot_q;
      bit_d       = w_base_bit;
      slot_d      = w_base_slot;
      if (i_step) begin
         if (w_base_bit == BIT_W'(SLOT_W - 1)) begin
            bit_d  = '0;
            slot_d = (w_base_slot == SLOT_CW'(NUM_CH - 1)) ? '0 : w_base_slot + 1'b1;
         end else begin
            bit_d  = w_base_bit + 1'b1;
         end
      end
   end

   // Position registers
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         bit_q  <= '0;
         slot_q <= '0;
      end else begin
         bit_q  <= bit_d;
         slot_q <= slot_d;
      end
   end

   assign o_bit_cnt  = bit_q;
   assign o_slot_cnt = slot_q;
   assign o_last_bit = (bit_q == BIT_W'(SLOT_W - 1)) && (slot_q == SLOT_CW'(NUM_CH - 1));

endmodule
`default_nettype wire

// File: rtl/tdm_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_rx
//  Brief    : NUM_CH-slot TDM serial-audio receiver, I2S or left-justified
//             framing, with valid/ready frame output, overrun and framing-
//             error pulses. Sequencing advances only on i_sclk_rise strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_rx
   import tdm_pkg::*;
#(
   parameter int DATA_RES = DEF_DATA_RES,
   parameter int SLOT_W   = DEF_SLOT_W,
   parameter int NUM_CH   = DEF_NUM_CH
) (
   input  logic      mclk,
   input  logic      reset_n,
   input  logic      i_sclk_rise,
   input  logic      i_fsync,
   input  logic      i_sdata,
   input  logic      i_mode,
   tdm_rx_if.master  rx
);

   localparam int BIT_W   = cnt_width(SLOT_W);
   localparam int SLOT_CW = cnt_width(NUM_CH);
   localparam int RES_W   = cnt_width(DATA_RES);

   typedef logic [NUM_CH-1:0][DATA_RES-1:0] frame_t;

   tdm_state_t state_q, state_d;
   logic       fs_prev_q, fs_prev_d;
   logic       mode_q, mode_d;
   logic       pend_q, pend_d;       // frame-start edge seen on the final bit
   frame_t     shreg_q, shreg_d;
   frame_t     data_q, data_d;
   logic       valid_q, valid_d;
   logic       ovr_q, ovr_d;
   logic       ferr_q, ferr_d;

   logic               w_edge;
   logic               w_start;
   logic               w_cap;
   logic               w_cap_first;
   logic               w_commit;
   logic               w_cnt_clear;
   logic               w_cnt_step;
   logic [BIT_W-1:0]   w_cap_bit;
   logic [SLOT_CW-1:0] w_cap_slot;
   logic [RES_W-1:0]   w_pos;
   logic [BIT_W-1:0]   w_bit_cnt;
   logic [SLOT_CW-1:0] w_slot_cnt;
   logic               w_last_bit;

   tdm_slot_counter #(
      .SLOT_W  (SLOT_W),
      .NUM_CH  (NUM_CH),
      .BIT_W   (BIT_W),
      .SLOT_CW (SLOT_CW)
   ) u_cnt (
      .mclk       (mclk),
      .reset_n    (reset_n),
      .i_clear    (w_cnt_clear),
      .i_step     (w_cnt_step),
      .o_bit_cnt  (w_bit_cnt),
      .o_slot_cnt (w_slot_cnt),
      .o_last_bit (w_last_bit)
   );

   // Frame-start is a falling fsync seen on a strobe
   assign w_edge = i_sclk_rise & fs_prev_q & ~i_fsync;

   // Next-state logic: sequencing, bit capture, commit and handshake
   always_comb begin
      state_d     = state_q;
      fs_prev_d   = i_sclk_rise ? i_fsync : fs_prev_q;
      mode_d      = mode_q;
      pend_d      = pend_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      valid_d     = valid_q;
      ovr_d       = 1'b0;
      ferr_d      = 1'b0;
      w_start     = 1'b0;
      w_cap       = 1'b0;
      w_cap_first = 1'b0;
      w_commit    = 1'b0;
      w_cnt_clear = 1'b0;
      w_cnt_step  = 1'b0;

      case (state_q)
         IDLE, WAIT: begin
            if (w_edge) w_start = 1'b1;
         end
         DELAY: begin
            if (w_edge) begin
               ferr_d  = 1'b1;
               w_start = 1'b1;
            end else if (i_sclk_rise) begin
               w_cap      = 1'b1;
               w_cnt_step = 1'b1;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (i_sclk_rise) begin
               if (w_last_bit) begin
                  // The frame is complete; an edge here is the next frame's
                  // I2S start, remembered so no bit of it is lost.
                  w_cap      = 1'b1;
                  w_cnt_step = 1'b1;
                  state_d    = DONE;
                  if (w_edge) begin
                     pend_d = 1'b1;
                     mode_d = i_mode;
                  end
               end else if (w_edge) begin
                  ferr_d  = 1'b1;
                  w_start = 1'b1;
               end else begin
                  w_cap      = 1'b1;
                  w_cnt_step = 1'b1;
               end
            end
         end
         DONE: begin
            // Strobes are assumed at least two mclk apart, so none lands here.
            // A remembered left-justified start cannot be honoured (its first
            // bit was the old frame's last), so it falls back to waiting.
            w_commit = 1'b1;
            pend_d   = 1'b0;
            if (pend_q && (mode_q == MODE_I2S)) begin
               state_d     = DELAY;
               w_cnt_clear = 1'b1;
            end else begin
               state_d     = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase

      // Frame start: latch mode; left-justified captures this bit as bit 0
      if (w_start) begin
         mode_d      = i_mode;
         w_cnt_clear = 1'b1;
         if (i_mode == MODE_LJ) begin
            state_d     = SHIFT;
            w_cap       = 1'b1;
            w_cap_first = 1'b1;
            w_cnt_step  = 1'b1;
         end else begin
            state_d     = DELAY;
         end
      end

      // Only the first DATA_RES bits of each slot are kept, MSB first
      w_cap_bit  = w_cap_first ? '0 : w_bit_cnt;
      w_cap_slot = w_cap_first ? '0 : w_slot_cnt;
      w_pos      = RES_W'(DATA_RES - 1 - int'(w_cap_bit));
      if (w_cap && (int'(w_cap_bit) < DATA_RES)) begin
         shreg_d[w_cap_slot][w_pos] = i_sdata;
      end

      // Output buffer: load when free or being drained, else drop and flag
      if (w_commit) begin
         if (!valid_q || rx.i_ready) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
         end else begin
            ovr_d   = 1'b1;
         end
      end else if (valid_q && rx.i_ready) begin
         valid_d = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         fs_prev_q <= 1'b0;
         mode_q    <= MODE_I2S;
         pend_q    <= 1'b0;
         shreg_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         fs_prev_q <= fs_prev_d;
         mode_q    <= mode_d;
         pend_q    <= pend_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
         ferr_q    <= ferr_d;
      end
   end

   assign rx.o_data      = data_q;
   assign rx.o_valid     = valid_q;
   assign rx.o_overrun   = ovr_q;
   assign rx.o_frame_err = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_rx
//  Brief    : Self-checking bench for tdm_rx (2-slot and 8-slot instances
//             sharing one serial stimulus stream).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_rx;

   logic mclk = 1'b0;
   logic reset_n;
   logic rise, fsync, sdata, mode;

   always #5 mclk = ~mclk;

   tdm_rx_if #(.NUM_CH(2), .DATA_RES(24)) bus2 ();
   tdm_rx_if #(.NUM_CH(8), .DATA_RES(24)) bus8 ();

   tdm_rx #(.DATA_RES(24), .SLOT_W(32), .NUM_CH(2)) u_dut2 (
      .mclk(mclk), .reset_n(reset_n), .i_sclk_rise(rise), .i_fsync(fsync),
      .i_sdata(sdata), .i_mode(mode), .rx(bus2)
   );

   tdm_rx #(.DATA_RES(24), .SLOT_W(32), .NUM_CH(8)) u_dut8 (
      .mclk(mclk), .reset_n(reset_n), .i_sclk_rise(rise), .i_fsync(fsync),
      .i_sdata(sdata), .i_mode(mode), .rx(bus8)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Accepted-frame / pulse monitors, sampled just after the falling edge
   int          acc2 = 0, acc8 = 0, ovr2 = 0, ferr2 = 0;
   logic [23:0] last2 [2];
   logic [23:0] last8 [8];

   always @(negedge mclk) begin
      #1;
      if (bus2.o_valid && bus2.i_ready) begin
         acc2++;
         for (int k = 0; k < 2; k++) last2[k] = bus2.o_data[k];
      end
      if (bus8.o_valid && bus8.i_ready) begin
         acc8++;
         for (int k = 0; k < 8; k++) last8[k] = bus8.o_data[k];
      end
      if (bus2.o_overrun)   ovr2++;
      if (bus2.o_frame_err) ferr2++;
   end

   logic [23:0] frame_v [8];

   typedef struct {
      logic        mode;
      logic        lj_t;   // 1 = left-justified timing, 0 = I2S timing
      logic [23:0] l;
      logic [23:0] r;
      logic        pad;
      logic [23:0] e0;
      logic [23:0] e1;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One sclk bit: strobe lasts one mclk, bits four mclk apart
   task automatic send_bit(input logic fs, input logic sd);
      @(negedge mclk);
      @(negedge mclk);
      @(negedge mclk);
      fsync = fs;
      sdata = sd;
      rise  = 1'b1;
      @(negedge mclk);
      rise  = 1'b0;
   endtask

   // Frame from frame_v; fsync high during the second half of the frame.
   // I2S timing sends a junk bit on the start strobe; max_bits>0 truncates.
   task automatic send_frame(input int nch, input logic lj_t, input logic pad,
                             input logic skip_edge, input logic end_edge, input int max_bits);
      int   total, nb, s, b;
      logic fs, sd;
      total = nch * 32;
      nb    = (max_bits > 0) ? max_bits : total;
      if (!skip_edge && !lj_t) send_bit(1'b0, 1'b1);
      for (int i = 0; i < nb; i++) begin
         s  = i / 32;
         b  = i % 32;
         sd = (b < 24) ? frame_v[s][23-b] : pad;
         fs = (i >= total / 2);
         if (end_edge && (i == total - 1)) fs = 1'b0;
         send_bit(fs, sd);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int a0, o0, f0;
      logic [23:0] e;

      vecs[0] = '{1'b0, 1'b0, 24'h800001, 24'h7FFFFE, 1'b0, 24'h800001, 24'h7FFFFE};
      vecs[1] = '{1'b1, 1'b1, 24'h800001, 24'h7FFFFE, 1'b0, 24'h800001, 24'h7FFFFE};
      vecs[2] = '{1'b1, 1'b0, 24'h800001, 24'h7FFFFE, 1'b0, 24'hC00000, 24'h3FFFFF};
      vecs[3] = '{1'b0, 1'b0, 24'h123456, 24'hFEDCBA, 1'b1, 24'h123456, 24'hFEDCBA};
      vecs[4] = '{1'b1, 1'b1, 24'h000000, 24'hFFFFFF, 1'b1, 24'h000000, 24'hFFFFFF};

      reset_n = 1'b0; rise = 1'b0; fsync = 1'b0; sdata = 1'b0; mode = 1'b0;
      bus2.i_ready = 1'b1;
      bus8.i_ready = 1'b1;
      repeat (3) @(negedge mclk);
      check("rst_valid", {31'd0, bus2.o_valid}, 32'd0);
      check("rst_data0", {8'd0, bus2.o_data[0]}, 32'd0);
      check("rst_ovr",   {31'd0, bus2.o_overrun}, 32'd0);
      check("rst_ferr",  {31'd0, bus2.o_frame_err}, 32'd0);
      reset_n = 1'b1;

      // Test 1: first frame, exact valid timing
      send_bit(1'b1, 1'b0);
      frame_v[0] = 24'h800001; frame_v[1] = 24'h7FFFFE;
      send_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("t1_valid_early", {31'd0, bus2.o_valid}, 32'd0);
      @(negedge mclk);
      check("t1_valid", {31'd0, bus2.o_valid}, 32'd1);
      check("t1_data0", {8'd0, bus2.o_data[0]}, 32'h800001);
      check("t1_data1", {8'd0, bus2.o_data[1]}, 32'h7FFFFE);
      @(negedge mclk);
      check("t1_valid_clear", {31'd0, bus2.o_valid}, 32'd0);

      // Table: modes, timings and pad bits
      for (int v = 0; v < 5; v++) begin
         mode = vecs[v].mode;
         frame_v[0] = vecs[v].l; frame_v[1] = vecs[v].r;
         a0 = acc2;
         send_frame(2, vecs[v].lj_t, vecs[v].pad, 1'b0, 1'b0, 0);
         repeat (3) @(negedge mclk);
         check($sformatf("vec%0d_count", v), acc2 - a0, 32'd1);
         check($sformatf("vec%0d_l", v), {8'd0, last2[0]}, {8'd0, vecs[v].e0});
         check($sformatf("vec%0d_r", v), {8'd0, last2[1]}, {8'd0, vecs[v].e1});
      end

      // Back-to-back I2S: next frame's start edge on the final bit
      mode = 1'b0;
      a0 = acc2;
      frame_v[0] = 24'hABCDEF; frame_v[1] = 24'h135790;
      send_frame(2, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      repeat (3) @(negedge mclk);
      check("b2b_p_l", {8'd0, last2[0]}, 32'hABCDEF);
      check("b2b_p_r", {8'd0, last2[1]}, 32'h135790);
      frame_v[0] = 24'h0F0F0F; frame_v[1] = 24'hF0F0F0;
      send_frame(2, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      repeat (3) @(negedge mclk);
      check("b2b_count", acc2 - a0, 32'd2);
      check("b2b_q_l", {8'd0, last2[0]}, 32'h0F0F0F);
      check("b2b_q_r", {8'd0, last2[1]}, 32'hF0F0F0);

      // Test 3: 8 slots, pad bits set
      for (int k = 0; k < 8; k++) frame_v[k] = 24'(24'h100000 * k + k);
      a0 = acc8;
      send_frame(8, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      repeat (3) @(negedge mclk);
      check("ch8_count", acc8 - a0, 32'd1);
      for (int k = 0; k < 8; k++) begin
         e = 24'(24'h100000 * k + k);
         check($sformatf("ch8_slot%0d", k), {8'd0, last8[k]}, {8'd0, e});
      end

      // Test 5: fsync falls after 40 of 64 bits
      a0 = acc2; f0 = ferr2;
      frame_v[0] = 24'h111111; frame_v[1] = 24'h222222;
      send_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 40);
      frame_v[0] = 24'h333333; frame_v[1] = 24'h444444;
      send_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      repeat (3) @(negedge mclk);
      check("ferr_pulses", ferr2 - f0, 32'd1);
      check("ferr_count", acc2 - a0, 32'd1);
      check("ferr_next_l", {8'd0, last2[0]}, 32'h333333);
      check("ferr_next_r", {8'd0, last2[1]}, 32'h444444);

      // Test 4: overrun with i_ready low, then accept-with-commit
      bus2.i_ready = 1'b0;
      a0 = acc2; o0 = ovr2;
      frame_v[0] = 24'hAAAAA1; frame_v[1] = 24'hAAAAA2;
      send_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      repeat (2) @(negedge mclk);
      check("ovr_a_valid", {31'd0, bus2.o_valid}, 32'd1);
      check("ovr_a_data", {8'd0, bus2.o_data[0]}, 32'hAAAAA1);
      frame_v[0] = 24'hBBBBB1; frame_v[1] = 24'hBBBBB2;
      send_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      repeat (2) @(negedge mclk);
      check("ovr_b_pulse", ovr2 - o0, 32'd1);
      check("ovr_b_hold0", {8'd0, bus2.o_data[0]}, 32'hAAAAA1);
      check("ovr_b_hold1", {8'd0, bus2.o_data[1]}, 32'hAAAAA2);
      frame_v[0] = 24'hCCCCC1; frame_v[1] = 24'hCCCCC2;
      send_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      bus2.i_ready = 1'b1;
      @(negedge mclk);
      bus2.i_ready = 1'b0;
      @(negedge mclk);
      check("ovr_c_acc_count", acc2 - a0, 32'd1);
      check("ovr_c_acc_data", {8'd0, last2[0]}, 32'hAAAAA1);
      check("ovr_c_no_ovr", ovr2 - o0, 32'd1);
      check("ovr_c_valid", {31'd0, bus2.o_valid}, 32'd1);
      check("ovr_c_data0", {8'd0, bus2.o_data[0]}, 32'hCCCCC1);
      check("ovr_c_data1", {8'd0, bus2.o_data[1]}, 32'hCCCCC2);
      bus2.i_ready = 1'b1;
      repeat (2) @(negedge mclk);
      check("ovr_c_drain", acc2 - a0, 32'd2);

      // Test 6: reset mid slot 1, fsync low on release
      frame_v[0] = 24'h555555; frame_v[1] = 24'h666666;
      send_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 45);
      reset_n = 1'b0;
      fsync   = 1'b0;
      @(negedge mclk);
      check("mrst_valid", {31'd0, bus2.o_valid}, 32'd0);
      check("mrst_data0", {8'd0, bus2.o_data[0]}, 32'd0);
      check("mrst_data1", {8'd0, bus2.o_data[1]}, 32'd0);
      check("mrst_flags", {30'd0, bus2.o_overrun, bus2.o_frame_err}, 32'd0);
      repeat (2) @(negedge mclk);
      reset_n = 1'b1;
      a0 = acc2; f0 = ferr2;
      for (int i = 0; i < 70; i++) send_bit(1'b0, i[0]);
      repeat (3) @(negedge mclk);
      check("mrst_no_frame", acc2 - a0, 32'd0);
      check("mrst_no_ferr", ferr2 - f0, 32'd0);
      send_bit(1'b1, 1'b0);
      frame_v[0] = 24'h777777; frame_v[1] = 24'h888888;
      send_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      repeat (3) @(negedge mclk);
      check("mrst_after_count", acc2 - a0, 32'd1);
      check("mrst_after_l", {8'd0, last2[0]}, 32'h777777);
      check("mrst_after_r", {8'd0, last2[1]}, 32'h888888);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
